// File: rtl/io_switch_debounce_pkg.sv
// Shared constants and FSM encoding for the switch debouncer.
package io_switch_debounce_pkg;

  localparam int unsigned IoWidth        = 8;
  localparam int unsigned DefTickDiv     = 50000;
  localparam int unsigned DefStableTicks = 10;

  typedef enum logic {
    StIdle   = 1'b0,
    StSettle = 1'b1
  } db_state_e;

endpackage

// File: rtl/io_switch_debounce_bit.sv
// One switch bit: two-FF synchroniser, settle FSM with tick counter, output and change pulse.
module io_switch_debounce_bit
  import io_switch_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DefStableTicks
) (
  input  logic io_clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic out,
  output logic pulse
);

  localparam int unsigned CntW    = $clog2(STABLE_TICKS) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

  logic            sync_meta_q;
  logic            sync_q;
  db_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            pulse_q, pulse_d;

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync_meta_q <= raw;
      sync_q      <= sync_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      pulse_q     <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sync_q != out_q) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        // A bounce back to the current level wins over a coincident tick.
        if (sync_q == out_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CntLast) begin
            out_d   = sync_q;
            pulse_d = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign out   = out_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/io_switch_debounce.sv
// Debounces raw switch inputs into in_port0, with a change pulse and sticky per-bit change flags.
module io_switch_debounce
  import io_switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = IoWidth,
  parameter int unsigned TICK_DIV     = DefTickDiv,
  parameter int unsigned STABLE_TICKS = DefStableTicks
) (
  input  logic             io_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] in_port0,
  output logic             in_changed,
  output logic [WIDTH-1:0] change_flags
);

  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic             tick;
  logic [WIDTH-1:0] pulse;
  logic [WIDTH-1:0] flags_q, flags_d;

  assign tick  = (pre_q == PreLast);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      flags_q <= '0;
    end else begin
      pre_q   <= pre_d;
      flags_q <= flags_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    io_switch_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .io_clk(io_clk),
      .reset (reset),
      .raw   (raw_in[i]),
      .tick  (tick),
      .out   (in_port0[i]),
      .pulse (pulse[i])
    );
  end

  // Set has priority over clear so an edge landing with clr_flags is never lost.
  always_comb begin
    flags_d = flags_q;
    if (clr_flags) flags_d = '0;
    flags_d = flags_d | pulse;
  end

  assign in_changed   = |pulse;
  assign change_flags = flags_q;

endmodule

// File: tb/tb_io_switch_debounce.sv
// Directed bench for io_switch_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_io_switch_debounce;

  logic       io_clk = 1'b0;
  logic       reset;
  logic [7:0] raw_in;
  logic       clr_flags;
  logic [7:0] in_port0;
  logic       in_changed;
  logic [7:0] change_flags;

  int checks = 0;
  int errors = 0;
  int n;
  int pulses;

  always #5 io_clk = ~io_clk;

  io_switch_debounce #(
    .WIDTH       (8),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .io_clk      (io_clk),
    .reset       (reset),
    .raw_in      (raw_in),
    .clr_flags   (clr_flags),
    .in_port0    (in_port0),
    .in_changed  (in_changed),
    .change_flags(change_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  // Cycles from now until in_port0 shows target; capped so a dead DUT still ends.
  task automatic wait_port(input logic [7:0] target, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (in_port0 !== target && cycles < 30);
  endtask

  initial begin
    // Reset with all switches high: nothing may leak through.
    reset     = 1'b1;
    raw_in    = 8'hFF;
    clr_flags = 1'b0;
    #1;
    repeat (3) step();
    check("rst_port", 32'(in_port0), 32'h00);
    check("rst_flags", 32'(change_flags), 32'h00);
    check("rst_changed", 32'(in_changed), 32'h0);
    repeat (4) step();
    check("rst_hold_port", 32'(in_port0), 32'h00);
    check("rst_hold_flags", 32'(change_flags), 32'h00);

    // Clean edge released together with reset.
    raw_in = 8'h05;
    reset  = 1'b0;
    wait_port(8'h05, n);
    check("clean_port", 32'(in_port0), 32'h05);
    check_rng("clean_latency", n, 9, 14);
    check("clean_changed_hi", 32'(in_changed), 32'h1);
    check("clean_flags_pre", 32'(change_flags), 32'h00);
    step();
    check("clean_changed_lo", 32'(in_changed), 32'h0);
    check("clean_flags", 32'(change_flags), 32'h05);

    // Bit 3 bouncing every 3 cycles never settles long enough.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) raw_in[3] = ~raw_in[3];
      step();
      if (in_changed) pulses++;
    end
    raw_in = 8'h05;
    for (int i = 0; i < 20; i++) begin
      step();
      if (in_changed) pulses++;
    end
    check("bounce_pulses", 32'(pulses), 32'h0);
    check("bounce_port", 32'(in_port0), 32'h05);

    // clr_flags coincides with bit 7 being accepted: bit 7 set survives, old flags clear.
    raw_in = 8'h85;
    wait_port(8'h85, n);
    check("race_port", 32'(in_port0), 32'h85);
    check("race_changed", 32'(in_changed), 32'h1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("race_flags", 32'(change_flags), 32'h80);
    check("race_changed_lo", 32'(in_changed), 32'h0);
    step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("lone_clear", 32'(change_flags), 32'h00);

    // Reset part-way through a settle must discard the count.
    reset  = 1'b1;
    raw_in = 8'h00;
    step();
    step();
    reset  = 1'b0;
    raw_in = 8'h01;
    repeat (6) step();
    reset = 1'b1;
    #1;
    check("midrst_port", 32'(in_port0), 32'h00);
    step();
    step();
    check("midrst_hold", 32'(in_port0), 32'h00);
    reset = 1'b0;
    wait_port(8'h01, n);
    check("midrst_after", 32'(in_port0), 32'h01);
    check_rng("midrst_latency", n, 9, 14);
    check("midrst_changed", 32'(in_changed), 32'h1);

    // Four bits change together: one pulse, all flags.
    reset  = 1'b1;
    raw_in = 8'h00;
    step();
    step();
    reset  = 1'b0;
    raw_in = 8'hF0;
    n = 0;
    do begin
      step();
      n++;
    end while (in_port0 === 8'h00 && n < 30);
    check("simul_port", 32'(in_port0), 32'hF0);
    check_rng("simul_latency", n, 9, 14);
    check("simul_changed_hi", 32'(in_changed), 32'h1);
    step();
    check("simul_changed_lo", 32'(in_changed), 32'h0);
    check("simul_flags", 32'(change_flags), 32'hF0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (in_changed) pulses++;
    end
    check("simul_single_pulse", 32'(pulses), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
